ble_packet_deframer: RTL

BLE_PACKET_DEFRAMER -- requirements
Module: ble_packet_deframer

---
 rtl/ble_packet_deframer.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ble_packet_deframer.sv
// BLE packet deframer: finds the access address in the recovered bit stream,
// dewhitens the PDU, emits header and payload bytes, and checks the CRC-24.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst          asynchronous active-low reset
//   update       recovered-bit clock; each rising edge carries one bit
//   value        demodulated bit, sampled on the update rising edge
//   access_addr  target access address (air order LSB first)
//   aa_tol       maximum Hamming distance accepted as an address match
//   channel      BLE channel index seeding the dewhitening LFSR
//   crc_init     CRC-24 preset value
//   byte_out     dewhitened header/payload byte, LSB = first air bit
//   byte_valid   one-cycle strobe qualifying byte_out
//   pkt_start    one-cycle pulse on access-address match
//   pkt_len      payload length from header byte 1
//   pkt_done     one-cycle pulse at end of packet or length abort
//   crc_ok       CRC result, valid at pkt_done, held until next pkt_start
//   len_err      length above MAX_LEN, valid at pkt_done, held likewise
module ble_packet_deframer #(
  parameter int unsigned MAX_LEN = 37
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        value,
  input  logic [31:0] access_addr,
  input  logic [2:0]  aa_tol,
  input  logic [5:0]  channel,
  input  logic [23:0] crc_init,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        pkt_start,
  output logic [7:0]  pkt_len,
  output logic        pkt_done,
  output logic        crc_ok,
  output logic        len_err
);

  localparam int unsigned AA_W   = 32;
  localparam int unsigned FILL_W = 6;
  localparam int unsigned DIST_W = 6;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned CRC_W  = 24;
  localparam int unsigned WH_W   = 7;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CRC_W-1:0]  CRC_POLY  = 24'h00065B;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(AA_W);
  localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(15);
  localparam logic [CNT_W-1:0]  CRC_LAST  = CNT_W'(23);

  typedef enum logic [2:0] {
    S_SEARCH,
    S_HEADER,
    S_PAYLOAD,
    S_CRC,
    S_DONE
  } state_e;

  // Number of set bits in the address-compare difference vector.
  function automatic logic [DIST_W-1:0] popcount(input logic [AA_W-1:0] x);
    logic [DIST_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(AA_W); i++) begin
      n = n + DIST_W'(x[i]);
    end
    return n;
  endfunction

  state_e              state_q, state_d;
  logic                update_q;
  logic [AA_W-1:0]     window_q, window_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [WH_W-1:0]     whiten_q, whiten_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [BYTE_W-1:0]   byte_sr_q, byte_sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   byte_out_q, byte_out_d;
  logic                byte_valid_q, byte_valid_d;
  logic                pkt_start_q, pkt_start_d;
  logic [BYTE_W-1:0]   pkt_len_q, pkt_len_d;
  logic                pkt_done_q, pkt_done_d;
  logic                crc_ok_q, crc_ok_d;
  logic                len_err_q, len_err_d;

  // Per-bit datapath terms, only consumed when bit_stb_c is high.
  logic                bit_stb_c;
  logic                d_bit_c;
  logic [AA_W-1:0]     win_next_c;
  logic [FILL_W-1:0]   fill_next_c;
  logic                aa_match_c;
  logic [CRC_W-1:0]    crc_next_c;
  logic [WH_W-1:0]     whiten_next_c;
  logic [BYTE_W-1:0]   byte_next_c;
  logic                byte_last_c;
  logic [CNT_W-1:0]    pay_last_c;
  logic                len_over_c;

  assign bit_stb_c   = update & ~update_q;
  assign d_bit_c     = value ^ whiten_q[WH_W-1];
  assign win_next_c  = {value, window_q[AA_W-1:1]};
  assign fill_next_c = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
  assign aa_match_c  = (fill_next_c == FILL_FULL) &&
                       (popcount(win_next_c ^ access_addr) <= DIST_W'(aa_tol));

  // CRC-24 shifts MSB out; the received CRC field drives the register to zero.
  assign crc_next_c  = {crc_q[CRC_W-2:0], 1'b0} ^
                       ((d_bit_c ^ crc_q[CRC_W-1]) ? CRC_POLY : '0);

  // Whitening LFSR x^7 + x^4 + 1, output taken from w[6].
  assign whiten_next_c = {whiten_q[5], whiten_q[4], whiten_q[3] ^ whiten_q[6],
                          whiten_q[2], whiten_q[1], whiten_q[0], whiten_q[6]};

  assign byte_next_c = {d_bit_c, byte_sr_q[BYTE_W-1:1]};
  assign byte_last_c = (bit_cnt_q[2:0] == 3'd7);
  // Last payload bit index is pkt_len*8-1; pkt_len is nonzero in PAYLOAD.
  assign pay_last_c  = {pkt_len_q - 8'd1, 3'b111};
  assign len_over_c  = 32'(byte_next_c) > MAX_LEN;

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    fill_d       = fill_q;
    whiten_d     = whiten_q;
    crc_d        = crc_q;
    byte_sr_d    = byte_sr_q;
    bit_cnt_d    = bit_cnt_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    pkt_start_d  = 1'b0;
    pkt_len_d    = pkt_len_q;
    pkt_done_d   = 1'b0;
    crc_ok_d     = crc_ok_q;
    len_err_d    = len_err_q;

    // Common per-bit work for every state that consumes PDU bits.
    if (bit_stb_c && (state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_CRC)) begin
      whiten_d  = whiten_next_c;
      crc_d     = crc_next_c;
      byte_sr_d = byte_next_c;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_SEARCH: begin
        if (bit_stb_c) begin
          window_d = win_next_c;
          fill_d   = fill_next_c;
          if (aa_match_c) begin
            state_d     = S_HEADER;
            pkt_start_d = 1'b1;
            crc_ok_d    = 1'b0;
            len_err_d   = 1'b0;
            // w[0]=1, w[1..6] = channel[5..0]
            whiten_d    = {channel[0], channel[1], channel[2], channel[3],
                           channel[4], channel[5], 1'b1};
            crc_d       = crc_init;
            byte_sr_d   = '0;
            bit_cnt_d   = '0;
          end
        end
      end

      S_HEADER: begin
        if (bit_stb_c) begin
          if (byte_last_c) begin
            byte_out_d   = byte_next_c;
            byte_valid_d = 1'b1;
          end
          if (bit_cnt_q == HDR_LAST) begin
            pkt_len_d = byte_next_c;
            bit_cnt_d = '0;
            if (len_over_c) begin
              state_d    = S_DONE;
              pkt_done_d = 1'b1;
              len_err_d  = 1'b1;
              crc_ok_d   = 1'b0;
            end else if (byte_next_c == '0) begin
              state_d = S_CRC;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end
      end

      S_PAYLOAD: begin
        if (bit_stb_c) begin
          if (byte_last_c) begin
            byte_out_d   = byte_next_c;
            byte_valid_d = 1'b1;
          end
          if (bit_cnt_q == pay_last_c) begin
            state_d   = S_CRC;
            bit_cnt_d = '0;
          end
        end
      end

      S_CRC: begin
        if (bit_stb_c && bit_cnt_q == CRC_LAST) begin
          state_d    = S_DONE;
          pkt_done_d = 1'b1;
          crc_ok_d   = (crc_next_c == '0);
          bit_cnt_d  = '0;
        end
      end

      // pkt_done is high this cycle; any bit strobe here is dropped.
      S_DONE: begin
        state_d  = S_SEARCH;
        window_d = '0;
        fill_d   = '0;
      end

      default: begin
        state_d  = S_SEARCH;
        window_d = '0;
        fill_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_SEARCH;
      update_q     <= 1'b0;
      window_q     <= '0;
      fill_q       <= '0;
      whiten_q     <= '0;
      crc_q        <= '0;
      byte_sr_q    <= '0;
      bit_cnt_q    <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_len_q    <= '0;
      pkt_done_q   <= 1'b0;
      crc_ok_q     <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      update_q     <= update;
      window_q     <= window_d;
      fill_q       <= fill_d;
      whiten_q     <= whiten_d;
      crc_q        <= crc_d;
      byte_sr_q    <= byte_sr_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      pkt_start_q  <= pkt_start_d;
      pkt_len_q    <= pkt_len_d;
      pkt_done_q   <= pkt_done_d;
      crc_ok_q     <= crc_ok_d;
      len_err_q    <= len_err_d;
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign pkt_start  = pkt_start_q;
  assign pkt_len    = pkt_len_q;
  assign pkt_done   = pkt_done_q;
  assign crc_ok     = crc_ok_q;
  assign len_err    = len_err_q;

endmodule
